// File: rtl/counter_share_arbiter.sv
// Shared W-bit counter serving N requesters through a round-robin arbiter.
// One granted op per cycle; the pre-op value and wrap flag are returned one cycle later.
module counter_share_arbiter #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_en,
    input  logic [N-1:0]   io_req_valid,
    input  logic [2*N-1:0] io_req_op,
    input  logic [W*N-1:0] io_req_data,
    output logic [N-1:0]   io_req_ready,
    output logic           io_resp_valid,
    output logic [1:0]     io_resp_id,
    output logic [W-1:0]   io_resp_data,
    output logic           io_resp_wrap,
    output logic [W-1:0]   io_count
);

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_ADD  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_t;

    logic [W-1:0] cnt;
    logic [1:0]   ptr;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [W-1:0] resp_data;
    logic         resp_wrap;

    logic [1:0]   op_arr [N];
    logic [W-1:0] data_arr [N];
    logic         grant_found;
    logic [1:0]   grant_idx;
    logic [1:0]   cand;
    logic         transfer;
    op_t          sel_op;
    logic [W-1:0] sel_data;
    logic [W:0]   result;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            op_arr[i]   = io_req_op[2*i +: 2];
            data_arr[i] = io_req_data[W*i +: W];
        end
    end

    // Search starts at ptr so the most recently served requester goes to the back of the line.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + 2'(k);
            if (!grant_found && io_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign transfer     = io_en && !reset && grant_found;
    assign io_req_ready = transfer ? (N'(1) << grant_idx) : '0;
    assign sel_op       = op_t'(op_arr[grant_idx]);
    assign sel_data     = data_arr[grant_idx];

    // One extra bit carries the INC/ADD overflow; LOAD and READ leave it clear.
    always_comb begin
        result = {1'b0, cnt};
        case (sel_op)
            OP_INC:  result = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
            OP_ADD:  result = {1'b0, cnt} + {1'b0, sel_data};
            OP_LOAD: result = {1'b0, sel_data};
            default: result = {1'b0, cnt};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_wrap  <= 1'b0;
        end else begin
            resp_valid <= transfer;
            if (transfer) begin
                cnt       <= result[W-1:0];
                ptr       <= grant_idx + 2'd1;
                resp_id   <= grant_idx;
                resp_data <= cnt;
                resp_wrap <= result[W];
            end
        end
    end

    assign io_resp_valid = resp_valid;
    assign io_resp_id    = resp_id;
    assign io_resp_data  = resp_data;
    assign io_resp_wrap  = resp_wrap;
    assign io_count      = cnt;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: directed vector table, randomized traffic
// against a behavioural model, and a bounded fairness check.
module tb_counter_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           io_en;
    logic [N-1:0]   io_req_valid;
    logic [2*N-1:0] io_req_op;
    logic [W*N-1:0] io_req_data;
    logic [N-1:0]   io_req_ready;
    logic           io_resp_valid;
    logic [1:0]     io_resp_id;
    logic [W-1:0]   io_resp_data;
    logic           io_resp_wrap;
    logic [W-1:0]   io_count;

    always #5 clk = ~clk;

    counter_share_arbiter #(.N(N), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_en        (io_en),
        .io_req_valid (io_req_valid),
        .io_req_op    (io_req_op),
        .io_req_data  (io_req_data),
        .io_req_ready (io_req_ready),
        .io_resp_valid(io_resp_valid),
        .io_resp_id   (io_resp_id),
        .io_resp_data (io_resp_data),
        .io_resp_wrap (io_resp_wrap),
        .io_count     (io_count)
    );

    typedef struct {
        logic         en;
        logic         rst;
        logic [3:0]   valid;
        logic [7:0]   op;
        logic [127:0] data;
        logic [3:0]   exp_ready;
        logic         exp_rv;
        logic [1:0]   exp_rid;
        logic [31:0]  exp_rdata;
        logic         exp_wrap;
        logic [31:0]  exp_count;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: counter value, next-in-line requester, last response.
    logic [31:0] m_cnt   = '0;
    int          m_ptr   = 0;
    logic        m_rv    = 1'b0;
    int          m_rid   = 0;
    logic [31:0] m_rdata = '0;
    logic        m_wrap  = 1'b0;
    logic [3:0]  last_ready;
    vec_t        vecs[$];

    function automatic logic [127:0] put(input int r, input logic [31:0] v);
        logic [127:0] d = '0;
        d[32*r +: 32] = v;
        return d;
    endfunction

    function automatic vec_t mk(input logic en, input logic rst, input logic [3:0] valid,
                                input logic [7:0] op, input logic [127:0] data,
                                input logic [3:0] rdy, input logic rv, input logic [1:0] rid,
                                input logic [31:0] rdata, input logic wrap, input logic [31:0] count);
        vec_t v;
        v.en = en; v.rst = rst; v.valid = valid; v.op = op; v.data = data;
        v.exp_ready = rdy; v.exp_rv = rv; v.exp_rid = rid;
        v.exp_rdata = rdata; v.exp_wrap = wrap; v.exp_count = count;
        return v;
    endfunction

    function automatic int modelGrant(input logic [3:0] valid);
        for (int k = 0; k < N; k++) begin
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic modelEdge(input vec_t v, input int g);
        longint unsigned s;
        logic [1:0]      op;
        logic [31:0]     d;
        if (v.rst) begin
            m_cnt = '0; m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_rdata = '0; m_wrap = 1'b0;
        end else if (v.en && g >= 0) begin
            op = v.op[2*g +: 2];
            d  = v.data[32*g +: 32];
            case (op)
                2'd0:    s = 64'(m_cnt) + 64'd1;
                2'd1:    s = 64'(m_cnt) + 64'(d);
                2'd2:    s = 64'(d);
                default: s = 64'(m_cnt);
            endcase
            m_rdata = m_cnt;
            m_wrap  = (op < 2'd2) && (s >= 64'h1_0000_0000);
            m_cnt   = s[31:0];
            m_rid   = g;
            m_ptr   = (g + 1) % N;
            m_rv    = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        io_en        = v.en;
        io_req_valid = v.valid;
        io_req_op    = v.op;
        io_req_data  = v.data;
        #1;
    endtask

    // Drive one cycle, check the combinational grant, then the registered results after the edge.
    task automatic runCycle(input vec_t v, input bit use_table);
        int         g;
        logic [3:0] exp_ready;
        applyStimulus(v);
        g = modelGrant(v.valid);
        exp_ready = (!v.rst && v.en && g >= 0) ? 4'(1 << g) : 4'b0000;
        last_ready = io_req_ready;
        checkOutput("ready", 64'(io_req_ready), 64'(exp_ready));
        if (use_table) checkOutput("tbl_ready", 64'(io_req_ready), 64'(v.exp_ready));
        @(posedge clk);
        modelEdge(v, g);
        #1;
        checkOutput("resp_valid", 64'(io_resp_valid), 64'(m_rv));
        checkOutput("resp_id",    64'(io_resp_id),    64'(m_rid));
        checkOutput("resp_data",  64'(io_resp_data),  64'(m_rdata));
        checkOutput("resp_wrap",  64'(io_resp_wrap),  64'(m_wrap));
        checkOutput("count",      64'(io_count),      64'(m_cnt));
        if (use_table) begin
            checkOutput("tbl_resp_valid", 64'(io_resp_valid), 64'(v.exp_rv));
            checkOutput("tbl_count",      64'(io_count),      64'(v.exp_count));
            if (v.exp_rv) begin
                checkOutput("tbl_resp_id",   64'(io_resp_id),   64'(v.exp_rid));
                checkOutput("tbl_resp_data", 64'(io_resp_data), 64'(v.exp_rdata));
                checkOutput("tbl_resp_wrap", 64'(io_resp_wrap), 64'(v.exp_wrap));
            end
        end
    endtask

    initial begin
        vec_t v;
        bit   seen;

        // Request under reset, then requester 2 INC three times.
        vecs.push_back(mk(1, 1, 4'b1111, 8'h00, 128'h0, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0100, 8'h00, 128'h0, 4'b0100, 1, 2, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'b0100, 8'h00, 128'h0, 4'b0100, 1, 2, 1, 0, 2));
        vecs.push_back(mk(1, 0, 4'b0100, 8'h00, 128'h0, 4'b0100, 1, 2, 2, 0, 3));
        vecs.push_back(mk(1, 0, 4'b0000, 8'h00, 128'h0, 4'b0000, 0, 2, 2, 0, 3));
        // LOAD near the top, then ADD 3 overflows.
        vecs.push_back(mk(1, 0, 4'b0001, 8'h02, put(0, 32'hFFFF_FFFE), 4'b0001, 1, 0, 3, 0, 32'hFFFF_FFFE));
        vecs.push_back(mk(1, 0, 4'b0010, 8'h04, put(1, 32'd3), 4'b0010, 1, 1, 32'hFFFF_FFFE, 1, 1));
        // LOAD 5, then READ by requester 1 with junk on an idle requester.
        vecs.push_back(mk(1, 0, 4'b1000, 8'h80, put(3, 32'd5), 4'b1000, 1, 3, 1, 0, 5));
        vecs.push_back(mk(1, 0, 4'b0010, 8'h3C, put(2, 32'hDEAD) | put(1, 32'h1234), 4'b0010, 1, 1, 5, 0, 5));
        // Disabled with everyone requesting, then resume at the held pointer.
        vecs.push_back(mk(0, 0, 4'b1111, 8'h00, 128'h0, 4'b0000, 0, 1, 5, 0, 5));
        vecs.push_back(mk(0, 0, 4'b1111, 8'h00, 128'h0, 4'b0000, 0, 1, 5, 0, 5));
        vecs.push_back(mk(1, 0, 4'b1111, 8'h00, 128'h0, 4'b0100, 1, 2, 5, 0, 6));
        vecs.push_back(mk(0, 0, 4'b1111, 8'h00, 128'h0, 4'b0000, 0, 2, 5, 0, 6));
        // INC, then reset in the following cycle kills its response.
        vecs.push_back(mk(1, 0, 4'b0001, 8'h00, 128'h0, 4'b0001, 1, 0, 6, 0, 7));
        vecs.push_back(mk(1, 1, 4'b1111, 8'h00, 128'h0, 4'b0000, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, 4'b1111, 8'h00, 128'h0, 4'(1 << (k % 4)), 1, 2'(k % 4), 32'(k), 0, 32'(k + 1)));

        foreach (vecs[i]) runCycle(vecs[i], 1'b1);

        // Random traffic, with operands biased toward the top of the range to hit wraps.
        for (int c = 0; c < 400; c++) begin
            v.en    = ($urandom_range(0, 7) != 0);
            v.rst   = ($urandom_range(0, 39) == 0);
            v.valid = 4'($urandom);
            v.op    = 8'($urandom);
            for (int r = 0; r < N; r++)
                v.data[32*r +: 32] = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                                  : 32'($urandom);
            runCycle(v, 1'b0);
        end

        // Fairness: with all requesters active, requester 3 must be served within N cycles.
        runCycle(mk(1, 1, 4'b0000, 8'h00, 128'h0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(1, 0, 4'b0001, 8'h00, 128'h0, 0, 0, 0, 0, 0, 0), 1'b0);
        seen = 1'b0;
        for (int c = 0; c < N && !seen; c++) begin
            runCycle(mk(1, 0, 4'b1111, 8'hFF, 128'h0, 0, 0, 0, 0, 0, 0), 1'b0);
            if (last_ready[3]) seen = 1'b1;
        end
        checkOutput("grant3_within_N", 64'(seen), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
